// File: rtl/des_key_schedule.sv
// DES key-schedule generator. It rotates the C/D halves of the PC-1 output and
// streams sixteen PC-2 round subkeys over a valid/ready handshake.
module des_key_schedule (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        decrypt,
  input  logic [55:0] pc1_key,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [3:0]  round_idx,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // PC-2 selection table: entry i gives the 1-based C||D bit feeding subkey bit i+1
  localparam logic [5:0] PC2 [48] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28,
    6'd15, 6'd6,  6'd21, 6'd10, 6'd23, 6'd19, 6'd12, 6'd4,
    6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40,
    6'd51, 6'd45, 6'd33, 6'd48, 6'd44, 6'd49, 6'd39, 6'd56,
    6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  logic [1:0]  r_state;
  logic        r_decrypt;
  logic [27:0] r_c;
  logic [27:0] r_d;

  logic        w_handshake;
  logic [4:0]  w_encRound;
  logic [4:0]  w_decRound;
  logic [27:0] w_nextC;
  logic [27:0] w_nextD;
  logic [47:0] w_nextSubkey;

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic twoBits);
    return twoBits ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic twoBits);
    return twoBits ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  // Rounds 1, 2, 9 and 16 shift by one position; all other rounds shift by two
  function automatic logic isDouble(input logic [4:0] round);
    return !((round == 5'd1) || (round == 5'd2) || (round == 5'd9) || (round == 5'd16));
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] result;
    result = '0;
    for (int i = 0; i < 48; i++) begin
      result[6'(47 - i)] = cd[6'd56 - PC2[i]];
    end
    return result;
  endfunction

  assign w_handshake = subkey_valid && subkey_ready;
  assign w_encRound  = {1'b0, round_idx} + 5'd2;
  assign w_decRound  = 5'd16 - {1'b0, round_idx};

  // Next C/D: first round taken from the key input, later ones from the registered halves
  always_comb begin
    w_nextC = r_c;
    w_nextD = r_d;
    if (r_state == S_IDLE) begin
      if (decrypt) begin
        w_nextC = pc1_key[55:28];
        w_nextD = pc1_key[27:0];
      end else begin
        w_nextC = rotl28(pc1_key[55:28], 1'b0);
        w_nextD = rotl28(pc1_key[27:0], 1'b0);
      end
    end else if (r_decrypt) begin
      w_nextC = rotr28(r_c, isDouble(w_decRound));
      w_nextD = rotr28(r_d, isDouble(w_decRound));
    end else begin
      w_nextC = rotl28(r_c, isDouble(w_encRound));
      w_nextD = rotl28(r_d, isDouble(w_encRound));
    end
  end

  assign w_nextSubkey = pc2({w_nextC, w_nextD});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_decrypt    <= 1'b0;
      r_c          <= '0;
      r_d          <= '0;
      subkey       <= '0;
      subkey_valid <= 1'b0;
      round_idx    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_decrypt    <= decrypt;
            r_c          <= w_nextC;
            r_d          <= w_nextD;
            subkey       <= w_nextSubkey;
            subkey_valid <= 1'b1;
            round_idx    <= '0;
            r_state      <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_handshake) begin
            if (round_idx == 4'd15) begin
              subkey_valid <= 1'b0;
              round_idx    <= '0;
              r_state      <= S_DONE;
            end else begin
              r_c       <= w_nextC;
              r_d       <= w_nextD;
              subkey    <= w_nextSubkey;
              round_idx <= round_idx + 4'd1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed testbench for des_key_schedule: checks subkey streams against the
// FIPS 46-3 example key schedule, under backpressure, restarts and resets.
module tb_des_key_schedule;

  logic        clk;
  logic        rst;
  logic        start;
  logic        decrypt;
  logic [55:0] pc1_key;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [3:0]  round_idx;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        decrypt;
    logic [55:0] key;
    logic [3:0]  idx;
    logic [47:0] expected;
  } vector_t;

  vector_t     vec [48];
  logic [47:0] kRef [16];
  logic [55:0] testKey;

  des_key_schedule dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .decrypt      (decrypt),
    .pc1_key      (pc1_key),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .round_idx    (round_idx),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [47:0] actual, input logic [47:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Runs one full schedule from the vector group; mode 0 free-flow, 1 backpressure, 2 start while busy
  task automatic applyStimulus(input int grp, input int mode);
    int hs;
    int cycles;
    int stallCnt;
    logic readyNow;
    hs = 0;
    cycles = 0;
    stallCnt = 0;
    decrypt = vec[grp*16].decrypt;
    pc1_key = vec[grp*16].key;
    subkey_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput($sformatf("first_valid g%0d m%0d", grp, mode), 48'(subkey_valid), 48'd1);
    while (hs < 16 && cycles < 2000) begin
      cycles++;
      checkOutput($sformatf("valid g%0d pos%0d", grp, hs), 48'(subkey_valid), 48'd1);
      checkOutput($sformatf("busy g%0d pos%0d", grp, hs), 48'(busy), 48'd1);
      checkOutput($sformatf("idx g%0d pos%0d", grp, hs), 48'(round_idx), 48'(vec[grp*16+hs].idx));
      checkOutput($sformatf("subkey g%0d pos%0d", grp, hs), subkey, vec[grp*16+hs].expected);
      if (mode == 1 && hs == 3 && stallCnt < 5) begin
        readyNow = 1'b0;
        stallCnt++;
      end else if (mode == 1) begin
        readyNow = 1'($urandom_range(0, 1));
      end else begin
        readyNow = 1'b1;
      end
      if (mode == 2 && hs == 7 && cycles == 8) begin
        start = 1'b1;
        pc1_key = 56'h123456789ABCDE;
        decrypt = 1'b1;
      end
      subkey_ready = readyNow;
      tick();
      start = 1'b0;
      if (readyNow) hs++;
    end
    if (hs < 16) begin
      failures++;
      checks++;
      $display("[TB] FAIL timeout g%0d: got %0d handshakes, expected 16", grp, hs);
    end
    checkOutput($sformatf("done_pulse g%0d", grp), 48'(done), 48'd1);
    checkOutput($sformatf("done_busy g%0d", grp), 48'(busy), 48'd0);
    checkOutput($sformatf("done_valid g%0d", grp), 48'(subkey_valid), 48'd0);
    checkOutput($sformatf("done_idx g%0d", grp), 48'(round_idx), 48'd0);
    tick();
    checkOutput($sformatf("done_clear g%0d", grp), 48'(done), 48'd0);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_valid"}, 48'(subkey_valid), 48'd0);
    checkOutput({tag, "_busy"}, 48'(busy), 48'd0);
    checkOutput({tag, "_done"}, 48'(done), 48'd0);
    checkOutput({tag, "_idx"}, 48'(round_idx), 48'd0);
    checkOutput({tag, "_subkey"}, subkey, 48'd0);
  endtask

  initial begin
    kRef = '{48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
             48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
             48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
             48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};
    testKey = 56'hF0CCAAF556678F;
    for (int n = 0; n < 16; n++) begin
      vec[n]    = '{1'b0, testKey, 4'(n), kRef[n]};
      vec[16+n] = '{1'b1, testKey, 4'(n), kRef[15-n]};
      vec[32+n] = '{1'b0, 56'd0,   4'(n), 48'd0};
    end

    rst = 1'b1;
    start = 1'b0;
    decrypt = 1'b0;
    pc1_key = '0;
    subkey_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    checkIdle("reset");

    $display("[TB] encrypt free-flowing");
    applyStimulus(0, 0);
    $display("[TB] decrypt free-flowing");
    applyStimulus(1, 0);
    $display("[TB] encrypt with backpressure");
    applyStimulus(0, 1);
    $display("[TB] start while busy");
    applyStimulus(0, 2);

    $display("[TB] reset mid-run");
    decrypt = 1'b0;
    pc1_key = testKey;
    subkey_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 9; n++) tick();
    checkOutput("pre_reset_idx", 48'(round_idx), 48'd9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkIdle("midreset");
    tick();
    checkOutput("idle_after_reset_valid", 48'(subkey_valid), 48'd0);
    applyStimulus(0, 0);

    $display("[TB] back-to-back zero key");
    applyStimulus(2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
